// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the multi-channel frequency divider.
package freq_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_t;

    // Channel-select width; a single channel still needs a 1-bit field.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: counter, active/shadow configuration, pending flag
// and registered div_out/tick outputs.
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = '0
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_divisor,
    input  mode_t            cfg_mode,
    output logic             cfg_pending,
    output logic             div_out,
    output logic             tick
);

    typedef struct packed {
        logic [WIDTH-1:0] divisor;
        mode_t            mode;
    } ch_cfg_t;

    localparam ch_cfg_t RESET_CFG = '{divisor: DEFAULT_DIV, mode: MODE_TOGGLE};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    ch_cfg_t          act_q, act_d;
    ch_cfg_t          shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             div_out_q, div_out_d;
    logic             tick_q, tick_d;
    logic             terminal;

    // >= so that a commit lowering the divisor below cnt wraps on the next edge.
    assign terminal = (cnt_q >= act_q.divisor);

    always_comb begin
        cnt_d     = cnt_q;
        act_d     = act_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        div_out_d = div_out_q;
        tick_d    = 1'b0;

        if (sync_clr) begin
            cnt_d     = '0;
            div_out_d = 1'b0;
            if (pending_q) begin
                act_d     = shadow_q;
                pending_d = 1'b0;
            end
        end else if (!enable) begin
            if (act_q.mode == MODE_PULSE) begin
                div_out_d = 1'b0;
            end
            if (pending_q) begin
                act_d     = shadow_q;
                pending_d = 1'b0;
                cnt_d     = '0;
            end
        end else if (terminal) begin
            cnt_d     = '0;
            tick_d    = 1'b1;
            // Output for this edge still follows the mode in force before commit.
            div_out_d = (act_q.mode == MODE_PULSE) ? 1'b1 : ~div_out_q;
            if (pending_q) begin
                act_d     = shadow_q;
                pending_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
            if (act_q.mode == MODE_PULSE) begin
                div_out_d = 1'b0;
            end
        end

        // A write is applied after any commit, so it always waits for the next boundary.
        if (cfg_wr) begin
            shadow_d  = '{divisor: cfg_divisor, mode: cfg_mode};
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            act_q     <= RESET_CFG;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
        end
    end

    assign cfg_pending = pending_q;
    assign div_out     = div_out_q;
    assign tick        = tick_q;

endmodule

// File: rtl/freq_divider_multi.sv
// Multi-channel runtime-programmable divider; decodes config writes and fans out to channels.
// Define FREQDIV_SYNC_CLR_EN to add the sync_clr input that phase-aligns all channels.
module freq_divider_multi
    import freq_div_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = '0,
    localparam int              CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              reset_n,
`ifdef FREQDIV_SYNC_CLR_EN
    input  logic              sync_clr,
`endif
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_divisor,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);

    logic  clr_all;
    mode_t wr_mode;

`ifdef FREQDIV_SYNC_CLR_EN
    assign clr_all = sync_clr;
`else
    assign clr_all = 1'b0;
`endif

    assign wr_mode = mode_t'(cfg_mode);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic wr_sel;

            // Select values at or above NUM_CH match no channel and are dropped.
            assign wr_sel = cfg_wr && (cfg_ch == CH_W'(gi));

            freq_div_channel #(
                .WIDTH       (WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_channel (
                .clk_in      (clk_in),
                .reset_n     (reset_n),
                .enable      (enable[gi]),
                .sync_clr    (clr_all),
                .cfg_wr      (wr_sel),
                .cfg_divisor (cfg_divisor),
                .cfg_mode    (wr_mode),
                .cfg_pending (cfg_pending[gi]),
                .div_out     (div_out[gi]),
                .tick        (tick[gi])
            );
        end
    endgenerate

endmodule

// File: doc/freq_divider_multi.md
Name: freq_divider_multi

Overview:
- Multi-channel, parametrised clock/tick divider. Successor of the single-channel toggle divider.
- Each channel divides clk_in by a runtime-programmable divisor and runs in one of two modes: 50%-duty toggle or one-cycle pulse.
- New divisor/mode values are shadowed and committed only at a period boundary, so the output never glitches.
- Feeds LED blink rates, audio sample strobes and scan timing across the design.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- WIDTH, 32, divisor and counter width in bits.
- DEFAULT_DIV, 0, active divisor loaded into every channel at reset.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel-select field; derived, not overridden.

Ports:
- clk_in  in  1  single clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  NUM_CH  per-channel run enable.
- cfg_wr  in  1  one-cycle config write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_divisor  in  WIDTH  new divisor D.
- cfg_mode  in  1  0 = toggle, 1 = pulse.
- cfg_pending  out  NUM_CH  shadow written but not yet committed.
- div_out  out  NUM_CH  divided output per channel (registered).
- tick  out  NUM_CH  one-cycle strobe at each terminal count (registered, mode-independent).

Behaviour:
- Reset (reset_n low at posedge): cnt = 0, act_div = DEFAULT_DIV, act_mode = toggle, shadow = 0, cfg_pending = 0, div_out = 0, tick = 0. Reset mid-period discards the partial count and any pending config.
- Per channel, per enabled edge:
  - Terminal when cnt >= act_div. Use >=, so a commit that lowers D below cnt wraps on the next edge.
  - On terminal: cnt <= 0; tick <= 1.
    - Toggle mode: div_out <= ~div_out.
    - Pulse mode: div_out <= 1.
    - If pending: act_div/act_mode <= shadow and pending <= 0. The output for this cycle still follows the old mode.
  - Otherwise: cnt <= cnt + 1; tick <= 0; pulse mode forces div_out <= 0; toggle mode holds.
- Period rules:
  - Terminal every D+1 enabled cycles.
  - Toggle output period is 2(D+1) cycles.
  - D = 0: toggle gives clk_in/2; pulse and tick are held high continuously.
  - D = 2^WIDTH-1 is legal; cnt never overflows because terminal is reached first.
- Latency: the first tick is high in the cycle after the (D+1)th enabled edge following reset release.
- Disabled (enable[i] = 0):
  - cnt holds, tick = 0.
  - Toggle mode holds div_out; pulse mode drives div_out = 0.
  - A pending config commits immediately and also clears cnt to 0.
  - Re-enabling resumes from the held cnt, or from 0 if a commit happened.
- Config writes:
  - cfg_wr with cfg_ch < NUM_CH writes that channel's shadow and sets pending. cfg_ch >= NUM_CH is ignored.
  - A write while pending overwrites the shadow; pending stays 1.
  - A write landing in the same cycle as that channel's terminal is captured in the shadow but commits at the next terminal, not the current one.
- Channels are fully independent; no cross-channel ordering.

Optional Feature:
- Macro FREQDIV_SYNC_CLR_EN.
- Defined: adds input sync_clr (1 bit). When sync_clr = 1 and reset_n = 1, every channel takes cnt <= 0, div_out <= 0, tick <= 0, and commits any pending shadow. Channels are phase-aligned from the next edge.
- sync_clr has lower priority than reset_n and higher priority than cfg_wr in the same cycle. That write is still captured in the shadow and commits at the next terminal.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package freq_div_pkg:
  - mode_t enum {MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1};
  - channel config struct {divisor, mode}.
- Sub-module freq_div_channel (one per channel, generate loop) holds cnt, act/shadow registers, pending flag and output logic.
- The top level only decodes cfg_ch and fans out the strobe.

Test Plan:
- Reset, DEFAULT_DIV = 0, all channels enabled, toggle mode -> div_out toggles every cycle; tick constantly 1 from the first enabled edge.
- ch0 D = 4 toggle, ch1 D = 4 pulse -> ch0 period 10 cycles at 50% duty; ch1 high 1 of every 5 cycles; both ticks coincide.
- ch2 D = 9, running; write D = 2 at cnt = 5 -> cfg_pending[2] = 1 until the terminal at cnt = 9, then the period becomes 3 cycles with no short or glitched pulse.
- Write issued in the exact terminal cycle of ch0 -> the old period repeats once more, then the new one applies; a write with cfg_ch = NUM_CH -> no change on any channel.
- ch3 D = 6, drop enable at cnt = 3 for 5 cycles -> cnt holds at 3, tick = 0, then the next terminal arrives 4 cycles after re-enable. A write while disabled commits immediately and cfg_pending drops next cycle.
- Assert reset_n low mid-period with a pending config -> all outputs 0, pending cleared, DEFAULT_DIV active. With FREQDIV_SYNC_CLR_EN: pulse sync_clr -> all channels restart aligned, first ticks at D+1 cycles.
